// File: rtl/prio_tree_pipe.sv
// Pipelined priority-selection tree for the interrupt controller.
// Reduces each accepted request vector to the winning pending source (index + priority).
// A register stage is inserted every StageLevels tree levels; the stream uses valid/ready.
//
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_flush               synchronous clear of every in-flight entry (wins over stall)
//   i_in_valid/o_in_ready request vector handshake
//   i_pending             per-source pending mask
//   i_prio                per-source priority, source n at [n*PrioBits +: PrioBits]
//   i_threshold           winner must strictly beat this; travels with the vector
//   o_out_valid/i_out_ready result handshake
//   o_out_found           a pending source beating the threshold exists
//   o_out_id, o_out_prio  winner index / priority, both zero when nothing was found
module prio_tree_pipe #(
    parameter int unsigned Width       = 8,
    parameter int unsigned PrioBits    = 4,
    parameter int unsigned IdxBits     = (Width > 1) ? $clog2(Width) : 1,
    parameter bit          Polarity    = 1'b0,
    parameter int unsigned StageLevels = 1
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_flush,
    input  logic                      i_in_valid,
    output logic                      o_in_ready,
    input  logic [Width-1:0]          i_pending,
    input  logic [Width*PrioBits-1:0] i_prio,
    input  logic [PrioBits-1:0]       i_threshold,
    output logic                      o_out_valid,
    input  logic                      i_out_ready,
    output logic                      o_out_found,
    output logic [IdxBits-1:0]        o_out_id,
    output logic [PrioBits-1:0]       o_out_prio
);

    localparam int unsigned Depth   = (Width > 1) ? $clog2(Width) : 0;
    localparam int unsigned Leaves  = 1 << Depth;
    localparam int unsigned NStages = (Depth == 0) ? 1 : (Depth + StageLevels - 1) / StageLevels;
    localparam int unsigned Last    = NStages - 1;

    // The left operand always carries the lower index, so the right one only wins when it is
    // pending and strictly better; equal priorities and all-idle pairs keep the lower index.
    function automatic logic take_right(input logic pa, input logic [PrioBits-1:0] a,
                                        input logic pb, input logic [PrioBits-1:0] b);
        if (!pb) return 1'b0;
        if (!pa) return 1'b1;
        return Polarity ? (b < a) : (b > a);
    endfunction

    // Leaves padded to a power of two; pad leaves are idle so they can never be found.
    logic [Leaves-1:0]               w_leaf_pend;
    logic [Leaves-1:0][PrioBits-1:0] w_leaf_prio;
    logic [Leaves-1:0][IdxBits-1:0]  w_leaf_id;

    for (genvar i = 0; i < Leaves; i++) begin : g_leaf
        if (i < Width) begin : g_real
            assign w_leaf_pend[i] = i_pending[i];
            assign w_leaf_prio[i] = i_prio[i*PrioBits +: PrioBits];
        end else begin : g_pad
            assign w_leaf_pend[i] = 1'b0;
            assign w_leaf_prio[i] = '0;
        end
        assign w_leaf_id[i] = IdxBits'(i);
    end

    // Stream control: a stalled output freezes the whole pipe, bubbles included.
    logic [NStages-1:0] r_valid;
    logic               w_stall;

    assign w_stall    = r_valid[Last] && !i_out_ready;
    assign o_in_ready = !w_stall;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= '0;
        end else if (i_flush) begin
            r_valid <= '0;
        end else if (!w_stall) begin
            r_valid[0] <= i_in_valid;
            for (int s = 1; s < NStages; s++) begin
                r_valid[s] <= r_valid[s-1];
            end
        end
    end

    for (genvar s = 0; s < NStages; s++) begin : g_stage
        localparam int unsigned LvBeg = s * StageLevels;
        localparam int unsigned LvEnd = ((s + 1) * StageLevels < Depth) ?
                                        (s + 1) * StageLevels : Depth;
        localparam int unsigned NLv   = LvEnd - LvBeg;
        localparam int unsigned NIn   = Leaves >> LvBeg;
        localparam int unsigned NOut  = Leaves >> LvEnd;

        logic [NOut-1:0]               r_pend;
        logic [NOut-1:0][PrioBits-1:0] r_prio;
        logic [NOut-1:0][IdxBits-1:0]  r_id;
        logic [PrioBits-1:0]           r_thr;
        logic [PrioBits-1:0]           w_thr_in;

        // Level 0 is the stage input; each further level halves the node count.
        for (genvar k = 0; k <= NLv; k++) begin : g_lvl
            localparam int unsigned N = NIn >> k;
            logic [N-1:0]               w_pend;
            logic [N-1:0][PrioBits-1:0] w_prio;
            logic [N-1:0][IdxBits-1:0]  w_id;

            if (k == 0) begin : g_src
                if (s == 0) begin : g_ports
                    assign w_pend = w_leaf_pend;
                    assign w_prio = w_leaf_prio;
                    assign w_id   = w_leaf_id;
                end else begin : g_prev
                    assign w_pend = g_stage[s-1].r_pend;
                    assign w_prio = g_stage[s-1].r_prio;
                    assign w_id   = g_stage[s-1].r_id;
                end
            end else begin : g_red
                for (genvar j = 0; j < N; j++) begin : g_node
                    logic w_sel;
                    assign w_sel = take_right(g_lvl[k-1].w_pend[2*j], g_lvl[k-1].w_prio[2*j],
                                              g_lvl[k-1].w_pend[2*j+1],
                                              g_lvl[k-1].w_prio[2*j+1]);
                    assign w_pend[j] = w_sel ? g_lvl[k-1].w_pend[2*j+1] : g_lvl[k-1].w_pend[2*j];
                    assign w_prio[j] = w_sel ? g_lvl[k-1].w_prio[2*j+1] : g_lvl[k-1].w_prio[2*j];
                    assign w_id[j]   = w_sel ? g_lvl[k-1].w_id[2*j+1]   : g_lvl[k-1].w_id[2*j];
                end
            end
        end

        if (s == 0) begin : g_thr_port
            assign w_thr_in = i_threshold;
        end else begin : g_thr_prev
            assign w_thr_in = g_stage[s-1].r_thr;
        end

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_pend <= '0;
                r_prio <= '0;
                r_id   <= '0;
                r_thr  <= '0;
            end else if (!w_stall) begin
                r_pend <= g_lvl[NLv].w_pend;
                r_prio <= g_lvl[NLv].w_prio;
                r_id   <= g_lvl[NLv].w_id;
                r_thr  <= w_thr_in;
            end
        end
    end

    // Threshold qualification on the single surviving node; reuses the strict compare.
    logic w_found;

    assign w_found = g_stage[Last].r_pend[0] &&
                     take_right(1'b1, g_stage[Last].r_thr, 1'b1, g_stage[Last].r_prio[0]);

    assign o_out_valid = r_valid[Last];
    assign o_out_found = w_found;
    assign o_out_id    = w_found ? g_stage[Last].r_id[0]   : '0;
    assign o_out_prio  = w_found ? g_stage[Last].r_prio[0] : '0;

endmodule

// File: tb/tb_prio_tree_pipe.sv
module tb_prio_tree_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush, in_valid, in_ready, out_valid, out_ready, found;
    logic [7:0]  pending;
    logic [31:0] prio;
    logic [3:0]  thr, oprio;
    logic [2:0]  id;

    logic        p_in_valid, p_in_ready, p_out_valid, p_found;
    logic [4:0]  p_pending;
    logic [19:0] p_prio;
    logic [3:0]  p_thr, p_oprio;
    logic [2:0]  p_id;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    prio_tree_pipe #(
        .Width(8), .PrioBits(4), .Polarity(1'b0), .StageLevels(1)
    ) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_in_valid(in_valid),
        .o_in_ready(in_ready), .i_pending(pending), .i_prio(prio), .i_threshold(thr),
        .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_found(found),
        .o_out_id(id), .o_out_prio(oprio)
    );

    prio_tree_pipe #(
        .Width(5), .PrioBits(4), .Polarity(1'b1), .StageLevels(2)
    ) u_dut_p (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(1'b0), .i_in_valid(p_in_valid),
        .o_in_ready(p_in_ready), .i_pending(p_pending), .i_prio(p_prio), .i_threshold(p_thr),
        .o_out_valid(p_out_valid), .i_out_ready(1'b1), .o_out_found(p_found),
        .o_out_id(p_id), .o_out_prio(p_oprio)
    );

    task automatic test_reset();
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fails++;
            $display("FAIL rst_in_ready: got %0b want 1", in_ready); end
        n_checks++; if (out_valid !== 1'b0 || found !== 1'b0 || id !== 3'd0 || oprio !== 4'd0)
        begin n_fails++;
            $display("FAIL rst_outputs: got v=%0b f=%0b id=%0d p=%0d want all 0",
                     out_valid, found, id, oprio); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1; pending = 8'hFF; prio = 32'h33933333; thr = 4'd0;
            @(negedge clk);
        end
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1 || id !== 3'd5) begin n_fails++;
            $display("FAIL pre_reset_result: got v=%0b id=%0d want v=1 id=5", out_valid, id); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0 || found !== 1'b0 || id !== 3'd0 || oprio !== 4'd0)
        begin n_fails++;
            $display("FAIL async_reset: got v=%0b f=%0b id=%0d p=%0d want all 0",
                     out_valid, found, id, oprio); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_checks++; if (out_valid !== 1'b0) begin n_fails++;
                $display("FAIL stale_after_reset[%0d]: got v=%0b want 0", c, out_valid); end
        end
    endtask

    task automatic test_basic();
        in_valid = 1'b1; pending = 8'hFF; prio = 32'h33933333; thr = 4'd0;
        @(negedge clk);
        in_valid = 1'b0;
        for (int c = 1; c <= 2; c++) begin
            n_checks++; if (out_valid !== 1'b0) begin n_fails++;
                $display("FAIL basic_early[%0d]: got v=%0b want 0", c, out_valid); end
            @(negedge clk);
        end
        n_checks++; if (out_valid !== 1'b1 || found !== 1'b1 || id !== 3'd5 || oprio !== 4'd9)
        begin n_fails++;
            $display("FAIL basic_result: got v=%0b f=%0b id=%0d p=%0d want 1 1 5 9",
                     out_valid, found, id, oprio); end
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_fails++;
            $display("FAIL basic_single: got v=%0b want 0", out_valid); end
    endtask

    task automatic test_ties_threshold();
        logic [7:0]  pend_t [6];
        logic [31:0] prio_t [6];
        logic [3:0]  thr_t  [6];
        logic        f_t    [6];
        logic [2:0]  id_t   [6];
        logic [3:0]  p_t    [6];
        pend_t = '{8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h44, 8'h80};
        prio_t = '{32'h27222722, 32'h27222722, 32'h27222722, 32'h27222722,
                   32'hF7222722, 32'hF7222722};
        thr_t  = '{4'd0, 4'd7, 4'd6, 4'd0, 4'd0, 4'd0};
        f_t    = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        id_t   = '{3'd2, 3'd0, 3'd2, 3'd0, 3'd2, 3'd7};
        p_t    = '{4'd7, 4'd0, 4'd7, 4'd0, 4'd7, 4'hF};
        for (int c = 0; c < 8; c++) begin
            if (c < 6) begin
                in_valid = 1'b1; pending = pend_t[c]; prio = prio_t[c]; thr = thr_t[c];
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (c >= 2) begin
                n_checks++;
                if (out_valid !== 1'b1 || found !== f_t[c-2] || id !== id_t[c-2] ||
                    oprio !== p_t[c-2]) begin
                    n_fails++;
                    $display("FAIL tie_thr[%0d]: got v=%0b f=%0b id=%0d p=%0d want 1 %0b %0d %0d",
                             c - 2, out_valid, found, id, oprio, f_t[c-2], id_t[c-2], p_t[c-2]);
                end
            end
        end
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_fails++;
            $display("FAIL tie_thr_drain: got v=%0b want 0", out_valid); end
    endtask

    task automatic test_stall();
        logic [2:0] ids [5];
        logic [3:0] pv  [5];
        int tx, rx, stall_left;
        bit stalled;
        ids = '{3'd1, 3'd3, 3'd5, 3'd7, 3'd0};
        pv  = '{4'd2, 4'd4, 4'd6, 4'd8, 4'd10};
        tx = 0; rx = 0; stall_left = 0; stalled = 1'b0;
        for (int cyc = 0; cyc < 40 && rx < 5; cyc++) begin
            if (!stalled && rx == 1 && out_valid) begin
                stalled = 1'b1; stall_left = 4;
            end
            out_ready = (stall_left == 0);
            if (tx < 5) begin
                in_valid = 1'b1; pending = 8'h01 << ids[tx]; prio = {8{pv[tx]}}; thr = 4'd0;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (stall_left > 0) begin
                n_checks++;
                if (in_ready !== 1'b0 || out_valid !== 1'b1 || id !== ids[1] || oprio !== pv[1])
                begin
                    n_fails++;
                    $display("FAIL stall_hold: got rdy=%0b v=%0b id=%0d p=%0d want 0 1 %0d %0d",
                             in_ready, out_valid, id, oprio, ids[1], pv[1]);
                end
            end
            if (out_valid && out_ready) begin
                n_checks++;
                if (found !== 1'b1 || id !== ids[rx] || oprio !== pv[rx]) begin
                    n_fails++;
                    $display("FAIL stall_order[%0d]: got f=%0b id=%0d p=%0d want 1 %0d %0d",
                             rx, found, id, oprio, ids[rx], pv[rx]);
                end
                rx++;
            end
            if (in_valid && in_ready) tx++;
            if (stall_left > 0) stall_left--;
            @(negedge clk);
        end
        n_checks++; if (rx != 5 || !stalled) begin n_fails++;
            $display("FAIL stall_count: got %0d results stalled=%0b want 5 1", rx, stalled); end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++; if (out_valid !== 1'b0) begin n_fails++;
                $display("FAIL stall_dup[%0d]: got v=%0b want 0", c, out_valid); end
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1; pending = 8'hFF; prio = 32'h33933333; thr = 4'd0;
            @(negedge clk);
        end
        n_checks++; if (out_valid !== 1'b1) begin n_fails++;
            $display("FAIL flush_prefill: got v=%0b want 1", out_valid); end
        out_ready = 1'b0; flush = 1'b1;
        in_valid = 1'b1; pending = 8'h02; prio = 32'h11111111;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            n_checks++; if (out_valid !== 1'b0) begin n_fails++;
                $display("FAIL flush_cleared[%0d]: got v=%0b want 0", c, out_valid); end
            @(negedge clk);
        end
        // Vector offered together with flush is accepted and then dropped.
        in_valid = 1'b1; pending = 8'h08; prio = 32'h22222222;
        @(negedge clk);
        flush = 1'b1; pending = 8'h04;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fails++;
            $display("FAIL flush_in_ready: got %0b want 1", in_ready); end
        @(negedge clk);
        flush = 1'b0; pending = 8'h10; prio = 32'h55555555;
        @(negedge clk);
        in_valid = 1'b0;
        for (int c = 1; c <= 2; c++) begin
            n_checks++; if (out_valid !== 1'b0) begin n_fails++;
                $display("FAIL flush_drop[%0d]: got v=%0b want 0", c, out_valid); end
            @(negedge clk);
        end
        n_checks++; if (out_valid !== 1'b1 || found !== 1'b1 || id !== 3'd4 || oprio !== 4'd5)
        begin n_fails++;
            $display("FAIL flush_after: got v=%0b f=%0b id=%0d p=%0d want 1 1 4 5",
                     out_valid, found, id, oprio); end
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_fails++;
            $display("FAIL flush_after_single: got v=%0b want 0", out_valid); end
    endtask

    task automatic test_params();
        logic [4:0] pend_t [5];
        logic [3:0] thr_t  [5];
        logic       f_t    [5];
        logic [2:0] id_t   [5];
        logic [3:0] p_t    [5];
        pend_t = '{5'b01110, 5'b01110, 5'b00000, 5'b11111, 5'b01000};
        thr_t  = '{4'hF, 4'd1, 4'hF, 4'hF, 4'hF};
        f_t    = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        id_t   = '{3'd1, 3'd0, 3'd0, 3'd4, 3'd3};
        p_t    = '{4'd1, 4'd0, 4'd0, 4'd0, 4'd8};
        n_checks++; if (p_in_ready !== 1'b1) begin n_fails++;
            $display("FAIL param_in_ready: got %0b want 1", p_in_ready); end
        for (int c = 0; c < 6; c++) begin
            if (c < 5) begin
                p_in_valid = 1'b1; p_pending = pend_t[c]; p_prio = 20'h08114; p_thr = thr_t[c];
            end else begin
                p_in_valid = 1'b0;
            end
            @(negedge clk);
            if (c == 0) begin
                n_checks++; if (p_out_valid !== 1'b0) begin n_fails++;
                    $display("FAIL param_latency: got v=%0b want 0", p_out_valid); end
            end else begin
                n_checks++;
                if (p_out_valid !== 1'b1 || p_found !== f_t[c-1] || p_id !== id_t[c-1] ||
                    p_oprio !== p_t[c-1]) begin
                    n_fails++;
                    $display("FAIL param[%0d]: got v=%0b f=%0b id=%0d p=%0d want 1 %0b %0d %0d",
                             c - 1, p_out_valid, p_found, p_id, p_oprio,
                             f_t[c-1], id_t[c-1], p_t[c-1]);
                end
            end
        end
        @(negedge clk);
        n_checks++; if (p_out_valid !== 1'b0) begin n_fails++;
            $display("FAIL param_drain: got v=%0b want 0", p_out_valid); end
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        pending = '0; prio = '0; thr = '0;
        p_in_valid = 1'b0; p_pending = '0; p_prio = '0; p_thr = '0;
        test_reset();
        test_basic();
        test_ties_threshold();
        test_stall();
        test_flush();
        test_params();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
